// File: rtl/segre_pkg.sv
// Shared types and sizes for the SEGRE data-side MMU: memory op sizes,
// responder FSM states and the store-queue entry layout.
package segre_pkg;

    localparam int ADDR_SIZE        = 32;
    localparam int WORD_SIZE        = 32;
    localparam int DCACHE_LANE_SIZE = 128;
    localparam int DCACHE_TAG_SIZE  = ADDR_SIZE - $clog2(DCACHE_LANE_SIZE / 8);

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ST_REQ   = 3'd1,
        FILL_REQ = 3'd2,
        RESP     = 3'd3,
        DONE     = 3'd4
    } mmu_dc_state_e;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
        memop_data_type_e     data_type;
    } stq_entry_t;

endpackage

// File: rtl/segre_mmu_dc_lru.sv
// Age-based LRU for the fully-associative data cache: per-line age registers,
// touch update and victim selection (lowest invalid line, else the oldest).
module segre_mmu_dc_lru #(
    parameter int NUM_LINES = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_LINES-1:0]         valid_i,
    input  logic                         touch_en_i,
    input  logic [$clog2(NUM_LINES)-1:0] touch_idx_i,
    output logic [$clog2(NUM_LINES)-1:0] victim_idx_o
);
    localparam int IDX_W = $clog2(NUM_LINES);

    logic [IDX_W-1:0] age_q [NUM_LINES];
    logic [IDX_W-1:0] touch_age;

    assign touch_age = age_q[touch_idx_i];

    // Ages stay a permutation: the touched line drops to 0, younger lines shift up by one.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_age
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    age_q[gi] <= IDX_W'(gi);
                end else if (touch_en_i) begin
                    if (touch_idx_i == IDX_W'(gi)) begin
                        age_q[gi] <= '0;
                    end else if (age_q[gi] < touch_age) begin
                        age_q[gi] <= age_q[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        victim_idx_o = '0;
        if (&valid_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (age_q[i] == IDX_W'(NUM_LINES - 1)) begin
                    victim_idx_o = IDX_W'(i);
                end
            end
        end else begin
            for (int i = NUM_LINES - 1; i >= 0; i--) begin
                if (!valid_i[i]) begin
                    victim_idx_o = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/segre_mmu_dcache.sv
// Data-side MMU responder: serves cache-lane fills, tracks shadow tags/LRU and
// drains write-through stores first. Define SEGRE_MMU_DCACHE_PERF_EN for perf counters.
module segre_mmu_dcache
    import segre_pkg::*;
#(
    parameter int ADDR_W    = ADDR_SIZE,
    parameter int WORD_W    = WORD_SIZE,
    parameter int LANE_W    = DCACHE_LANE_SIZE,
    parameter int NUM_LINES = 4,
    parameter int STQ_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         dc_miss_i,
    input  logic [ADDR_W-1:0]            dc_addr_i,
    input  logic                         dc_access_i,
    input  logic                         dc_store_i,
    input  logic [WORD_W-1:0]            dc_store_data_i,
    input  memop_data_type_e             dc_store_type_i,
    output logic                         dc_data_rdy_o,
    output logic [LANE_W-1:0]            dc_data_o,
    output logic [$clog2(NUM_LINES)-1:0] dc_lru_index_o,
    output logic                         dc_store_full_o,
    output logic                         mm_rd_req_o,
    output logic                         mm_wr_req_o,
    output logic [ADDR_W-1:0]            mm_addr_o,
    output logic [WORD_W-1:0]            mm_wr_data_o,
    output memop_data_type_e             mm_wr_type_o,
    input  logic                         mm_rdy_i,
    input  logic [LANE_W-1:0]            mm_data_i
`ifdef SEGRE_MMU_DCACHE_PERF_EN
    ,
    output logic [31:0]                  perf_fills_o,
    output logic [31:0]                  perf_hits_o,
    output logic [31:0]                  perf_stores_o
`endif
);
    localparam int OFF_W = $clog2(LANE_W / 8);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int PTR_W = $clog2(STQ_DEPTH);

    mmu_dc_state_e     state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [IDX_W-1:0]  victim_q, victim_d;
    logic [LANE_W-1:0] dc_data_q;
    logic [IDX_W-1:0]  dc_idx_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q [NUM_LINES];

    stq_entry_t        stq_q [STQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    cnt_q;
    stq_entry_t        stq_head;
    logic              stq_full, stq_push, stq_pop;

    logic              resp, hit, touch_en;
    logic [IDX_W-1:0]  hit_idx, touch_idx, victim_idx;
    logic [TAG_W-1:0]  acc_tag;

    assign stq_head = stq_q[rd_ptr_q];
    assign stq_full = (cnt_q == (PTR_W + 1)'(STQ_DEPTH));
    assign stq_pop  = (state_q == ST_REQ) && mm_rdy_i;
    assign stq_push = dc_store_i && (!stq_full || stq_pop);
    assign resp     = (state_q == RESP);
    assign acc_tag  = dc_addr_i[ADDR_W-1:OFF_W];

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == acc_tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // The fill's own touch takes priority over a same-cycle access hit.
    assign touch_en  = resp || (dc_access_i && hit);
    assign touch_idx = resp ? victim_q : hit_idx;

    segre_mmu_dc_lru #(.NUM_LINES(NUM_LINES)) u_lru (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_q),
        .touch_en_i   (touch_en),
        .touch_idx_i  (touch_idx),
        .victim_idx_o (victim_idx)
    );

    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        victim_d     = victim_q;
        mm_rd_req_o  = 1'b0;
        mm_wr_req_o  = 1'b0;
        mm_addr_o    = '0;
        mm_wr_data_o = '0;
        mm_wr_type_o = WORD;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    state_d = ST_REQ;
                end else if (dc_miss_i) begin
                    fill_addr_d = {dc_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    victim_d    = victim_idx;
                    state_d     = FILL_REQ;
                end
            end
            ST_REQ: begin
                mm_wr_req_o  = 1'b1;
                mm_addr_o    = stq_head.addr;
                mm_wr_data_o = stq_head.data;
                mm_wr_type_o = stq_head.data_type;
                if (mm_rdy_i) state_d = IDLE;
            end
            FILL_REQ: begin
                mm_rd_req_o = 1'b1;
                mm_addr_o   = fill_addr_q;
                if (mm_rdy_i) state_d = RESP;
            end
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            victim_q    <= '0;
            dc_data_q   <= '0;
            dc_idx_q    <= '0;
            valid_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            victim_q    <= victim_d;
            if ((state_q == FILL_REQ) && mm_rdy_i) begin
                dc_data_q <= mm_data_i;
                dc_idx_q  <= victim_q;
            end
            if (resp) valid_q[victim_q] <= 1'b1;
            if (stq_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (stq_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (PTR_W + 1)'(stq_push) - (PTR_W + 1)'(stq_pop);
        end
    end

    // Tag and queue payload storage carries no reset; valid bits and count guard it.
    always_ff @(posedge clk_i) begin
        if (resp) tag_q[victim_q] <= fill_addr_q[ADDR_W-1:OFF_W];
        if (stq_push) begin
            stq_q[wr_ptr_q] <= '{addr: dc_addr_i, data: dc_store_data_i, data_type: dc_store_type_i};
        end
    end

    assign dc_data_rdy_o   = resp;
    assign dc_data_o       = dc_data_q;
    assign dc_lru_index_o  = dc_idx_q;
    assign dc_store_full_o = stq_full;

    stq_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(dc_store_i && stq_full && !stq_pop));

`ifdef SEGRE_MMU_DCACHE_PERF_EN
    logic [31:0] perf_fills_q, perf_hits_q, perf_stores_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_fills_q  <= '0;
            perf_hits_q   <= '0;
            perf_stores_q <= '0;
        end else begin
            if (resp && (perf_fills_q != '1)) perf_fills_q <= perf_fills_q + 1'b1;
            if (dc_access_i && hit && (perf_hits_q != '1)) perf_hits_q <= perf_hits_q + 1'b1;
            if (stq_pop && (perf_stores_q != '1)) perf_stores_q <= perf_stores_q + 1'b1;
        end
    end

    assign perf_fills_o  = perf_fills_q;
    assign perf_hits_o   = perf_hits_q;
    assign perf_stores_o = perf_stores_q;
`endif

endmodule

// File: tb/tb_segre_mmu_dcache.sv
// Scoreboard bench for segre_mmu_dcache: expected memory requests and fills are
// queued as stimulus is driven and checked when the DUT produces them.
module tb_segre_mmu_dcache;
    import segre_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             dc_miss_i, dc_access_i, dc_store_i;
    logic [31:0]      dc_addr_i, dc_store_data_i;
    memop_data_type_e dc_store_type_i;
    logic             dc_data_rdy_o, dc_store_full_o;
    logic [127:0]     dc_data_o;
    logic [1:0]       dc_lru_index_o;
    logic             mm_rd_req_o, mm_wr_req_o, mm_rdy_i;
    logic [31:0]      mm_addr_o, mm_wr_data_o;
    memop_data_type_e mm_wr_type_o;
    logic [127:0]     mm_data_i;
`ifdef SEGRE_MMU_DCACHE_PERF_EN
    logic [31:0]      perf_fills, perf_hits, perf_stores;
`endif

    segre_mmu_dcache dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dc_miss_i(dc_miss_i), .dc_addr_i(dc_addr_i), .dc_access_i(dc_access_i),
        .dc_store_i(dc_store_i), .dc_store_data_i(dc_store_data_i),
        .dc_store_type_i(dc_store_type_i),
        .dc_data_rdy_o(dc_data_rdy_o), .dc_data_o(dc_data_o),
        .dc_lru_index_o(dc_lru_index_o), .dc_store_full_o(dc_store_full_o),
        .mm_rd_req_o(mm_rd_req_o), .mm_wr_req_o(mm_wr_req_o), .mm_addr_o(mm_addr_o),
        .mm_wr_data_o(mm_wr_data_o), .mm_wr_type_o(mm_wr_type_o),
        .mm_rdy_i(mm_rdy_i), .mm_data_i(mm_data_i)
`ifdef SEGRE_MMU_DCACHE_PERF_EN
        , .perf_fills_o(perf_fills), .perf_hits_o(perf_hits), .perf_stores_o(perf_stores)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             is_wr;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        memop_data_type_e wtype;
        logic [127:0]     rlane;
        int               lat;
    } mm_exp_t;

    typedef struct {
        logic [127:0] lane;
        logic [1:0]   idx;
    } fill_exp_t;

    mm_exp_t   mm_q[$];
    fill_exp_t fill_q[$];
    int n_chk   = 0;
    int n_bad   = 0;
    int wr_done = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        dc_miss_i = 1'b0; dc_access_i = 1'b0; dc_store_i = 1'b0;
        dc_addr_i = '0; dc_store_data_i = '0; dc_store_type_i = WORD;
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic start_miss(input logic [31:0] a, input logic [127:0] lane,
                              input logic [1:0] idx, input bit expect_fill);
        mm_q.push_back('{is_wr: 1'b0, addr: {a[31:4], 4'h0}, wdata: 32'h0, wtype: WORD,
                         rlane: lane, lat: 5});
        if (expect_fill) fill_q.push_back('{lane: lane, idx: idx});
        dc_addr_i = a;
        dc_miss_i = 1'b1;
    endtask

    task automatic finish_miss();
        int n = 0;
        while (!dc_data_rdy_o && n < 200) begin
            tick();
            n++;
        end
        chk("miss_timeout", n < 200, 1'b1);
        dc_miss_i = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [1:0] idx);
        logic [31:0] al;
        al = {a[31:4], 4'h0};
        start_miss(a, {4{al}}, idx, 1'b1);
        finish_miss();
        tick();
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
        mm_q.push_back('{is_wr: 1'b1, addr: a, wdata: d, wtype: t, rlane: '0, lat: 3});
        dc_store_i = 1'b1; dc_addr_i = a; dc_store_data_i = d; dc_store_type_i = t;
        tick();
        dc_store_i = 1'b0;
    endtask

    // Memory model: checks each new request against the scoreboard, answers after a latency.
    initial begin : responder
        mm_exp_t e;
        bit got_e, abort;
        int lat;
        logic [127:0] lane;
        mm_rdy_i  = 1'b0;
        mm_data_i = '0;
        forever begin
            tick();
            if (!rst_i && (mm_rd_req_o || mm_wr_req_o)) begin
                got_e = (mm_q.size() > 0);
                chk("mm_pending", got_e, 1'b1);
                lat  = 1;
                lane = '0;
                if (got_e) begin
                    e = mm_q.pop_front();
                    chk("mm_kind", mm_wr_req_o, e.is_wr);
                    chk("mm_addr", mm_addr_o, e.addr);
                    if (e.is_wr) begin
                        chk("mm_wdata", mm_wr_data_o, e.wdata);
                        chk("mm_wtype", mm_wr_type_o, e.wtype);
                    end
                    lat  = e.lat;
                    lane = e.rlane;
                end
                $display("mm %s addr=%08h data=%08h", mm_wr_req_o ? "wr" : "rd", mm_addr_o, mm_wr_data_o);
                abort = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    tick();
                    if (rst_i || !(mm_rd_req_o || mm_wr_req_o)) abort = 1'b1;
                end
                if (!abort) begin
                    if (got_e) chk("mm_addr_hold", mm_addr_o, e.addr);
                    mm_rdy_i  = 1'b1;
                    mm_data_i = lane;
                    if (mm_wr_req_o) wr_done++;
                    tick();
                    mm_rdy_i  = 1'b0;
                    mm_data_i = '0;
                end
            end
        end
    end

    initial begin : fill_mon
        fill_exp_t f;
        logic prev_rdy;
        prev_rdy = 1'b0;
        forever begin
            tick();
            if (dc_data_rdy_o) begin
                chk("rdy_pulse", prev_rdy, 1'b0);
                chk("fill_pending", fill_q.size() > 0, 1'b1);
                if (fill_q.size() > 0) begin
                    f = fill_q.pop_front();
                    chk("fill_lane", dc_data_o, f.lane);
                    chk("fill_idx", dc_lru_index_o, f.idx);
                end
                $display("fill idx=%0d lane=%032h", dc_lru_index_o, dc_data_o);
            end
            prev_rdy = dc_data_rdy_o;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] lane_a5;
        logic [31:0]  al;
        int base, n;
        lane_a5 = {16{8'hA5}};

        do_reset();
        chk("rst_rdy", dc_data_rdy_o, 1'b0);
        chk("rst_rd_req", mm_rd_req_o, 1'b0);
        chk("rst_wr_req", mm_wr_req_o, 1'b0);
        chk("rst_addr", mm_addr_o, 32'h0);
        chk("rst_wdata", mm_wr_data_o, 32'h0);
        chk("rst_wtype", mm_wr_type_o, WORD);
        chk("rst_full", dc_store_full_o, 1'b0);
        chk("rst_data", dc_data_o, 128'h0);
        chk("rst_idx", dc_lru_index_o, 2'd0);

        // Cold miss: lane-aligned read, 5-cycle memory latency, victim 0.
        start_miss(32'h0000_1234, lane_a5, 2'd0, 1'b1);
        finish_miss();
        repeat (3) tick();
        chk("data_hold", dc_data_o, lane_a5);
        chk("rdy_low", dc_data_rdy_o, 1'b0);

        // Fill order then LRU: access to line 0 makes line 1 the oldest.
        do_reset();
        do_miss(32'h000, 2'd0);
        do_miss(32'h100, 2'd1);
        do_miss(32'h200, 2'd2);
        do_miss(32'h300, 2'd3);
        dc_addr_i = 32'h000; dc_access_i = 1'b1;
        tick();
        dc_access_i = 1'b0;
        chk("idx_hold", dc_lru_index_o, 2'd3);
        do_miss(32'h400, 2'd1);

        // Store priority: both queued writes precede the pending fill.
        push_store(32'h40, 32'hDEAD_BEEF, WORD);
        push_store(32'h44, 32'h0000_0011, BYTE);
        chk("stq_full", dc_store_full_o, 1'b1);
        base = wr_done;
        al = 32'h500;
        start_miss(32'h500, {4{al}}, 2'd2, 1'b1);
        n = 0;
        while (dc_store_full_o && n < 100) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk("full_clr_after_pop1", wr_done - base, 1);
        finish_miss();
        tick();

        // Full queue: push and pop in the same cycle keeps count at 2 and order intact.
        push_store(32'h80, 32'h0000_0001, WORD);
        push_store(32'h84, 32'h0000_BEEF, HALF);
        chk("stq_full2", dc_store_full_o, 1'b1);
        base = wr_done;
        mm_q.push_back('{is_wr: 1'b1, addr: 32'h88, wdata: 32'h5A, wtype: BYTE, rlane: '0, lat: 3});
        n = 0;
        while (!mm_rdy_i && n < 100) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk("pop_seen", mm_rdy_i, 1'b1);
        dc_store_i = 1'b1; dc_addr_i = 32'h88; dc_store_data_i = 32'h5A; dc_store_type_i = BYTE;
        tick();
        dc_store_i = 1'b0;
        chk("full_pushpop", dc_store_full_o, 1'b1);
        n = 0;
        while ((wr_done - base) < 3 && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("stq_drained", wr_done - base, 3);
        chk("stq_not_full", dc_store_full_o, 1'b0);
`ifdef SEGRE_MMU_DCACHE_PERF_EN
        chk("perf_fills", perf_fills, 32'd6);
        chk("perf_hits", perf_hits, 32'd1);
        chk("perf_stores", perf_stores, 32'd5);
`endif

        // Reset mid-fill: request drops at once, no fill response, lines invalidated.
        al = 32'h600;
        start_miss(32'h600, {4{al}}, 2'd0, 1'b0);
        n = 0;
        while (!mm_rd_req_o && n < 50) begin
            tick();
            n++;
        end
        chk("fill_req_seen", mm_rd_req_o, 1'b1);
        repeat (2) tick();
        rst_i = 1'b1;
        dc_miss_i = 1'b0;
        #1;
        chk("rst_rd_req_drop", mm_rd_req_o, 1'b0);
        chk("rst_mid_rdy", dc_data_rdy_o, 1'b0);
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        do_miss(32'h700, 2'd0);
        do_miss(32'h800, 2'd1);

        repeat (3) tick();
        chk("mm_left", mm_q.size(), 0);
        chk("fill_left", fill_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
